fraction_reducer: RTL and testbench

- Reduces a 16-bit fraction num/den to lowest terms.
- Acts as the requesting side of the team's GCD core handshake:
  - drives `start`/`a`/`b` into a `Greatest_Common_Divisor` instance;
  - waits for `done`/`gcd`;
  - divides both operands by the result with a shift-subtract divider.
- Sits between an upstream valid/ready operand source and a downstream valid/ready consumer.

---
 rtl/fraction_reducer_if.sv | 33 +++
 rtl/fraction_reducer.sv | 155 +++++++++++++++
 tb/tb_fraction_reducer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fraction_reducer_if.sv
`default_nettype none
// ============================================================================
// Module  : fraction_reducer_if
// Brief   : Operand/result stream plus GCD-core request bundle for the reducer.
// Revision: 1.0
// ============================================================================
interface fraction_reducer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] num;
    logic [15:0] den;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] red_num;
    logic [15:0] red_den;
    logic        err;
    logic        gcd_start;
    logic [15:0] gcd_a;
    logic [15:0] gcd_b;
    logic        gcd_done;
    logic [15:0] gcd_result;

    modport slave (
        input  in_valid, num, den, out_ready, gcd_done, gcd_result,
        output in_ready, out_valid, red_num, red_den, err, gcd_start, gcd_a, gcd_b
    );

    modport master (
        output in_valid, num, den, out_ready, gcd_done, gcd_result,
        input  in_ready, out_valid, red_num, red_den, err, gcd_start, gcd_a, gcd_b
    );
endinterface
`default_nettype wire

// File: rtl/fraction_reducer.sv
`default_nettype none
// ============================================================================
// Module  : fraction_reducer
// Brief   : Reduces num/den to lowest terms via an external GCD core and two
//           parallel restoring dividers.
// Revision: 1.0
// ============================================================================
module fraction_reducer (
    input  logic              clk,
    input  logic              rst_n,
    fraction_reducer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DIV  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] num_q, num_d;
    logic [15:0] den_q, den_d;
    logic [15:0] g_q, g_d;
    logic [15:0] rn_q, rn_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] qn_q, qn_d;
    logic [15:0] qd_q, qd_d;
    logic [15:0] red_num_q, red_num_d;
    logic [15:0] red_den_q, red_den_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;

    // 17-bit partial remainders keep the compare exact for g up to 65535.
    logic [16:0] w_n_shift;
    logic [16:0] w_d_shift;
    logic        w_n_ge;
    logic        w_d_ge;

    assign w_n_shift = {rn_q, num_q[cnt_q]};
    assign w_d_shift = {rd_q, den_q[cnt_q]};
    assign w_n_ge    = (w_n_shift >= {1'b0, g_q});
    assign w_d_ge    = (w_d_shift >= {1'b0, g_q});

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        den_d     = den_q;
        g_d       = g_q;
        rn_d      = rn_q;
        rd_d      = rd_q;
        qn_d      = qn_q;
        qd_d      = qd_q;
        red_num_d = red_num_q;
        red_den_d = red_den_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    num_d   = bus.num;
                    den_d   = bus.den;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Hold off while the core still shows done from a prior job.
                if (!bus.gcd_done) state_d = WAIT;
            end
            WAIT: begin
                if (bus.gcd_done) begin
                    g_d = bus.gcd_result;
                    if (bus.gcd_result == 16'd0) begin
                        red_num_d = 16'd0;
                        red_den_d = 16'd0;
                        err_d     = 1'b1;
                        state_d   = OUT;
                    end else begin
                        err_d   = 1'b0;
                        rn_d    = 16'd0;
                        rd_d    = 16'd0;
                        qn_d    = 16'd0;
                        qd_d    = 16'd0;
                        cnt_d   = 4'd15;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (w_n_ge) begin
                    rn_d        = w_n_shift[15:0] - g_q;
                    qn_d[cnt_q] = 1'b1;
                end else begin
                    rn_d = w_n_shift[15:0];
                end
                if (w_d_ge) begin
                    rd_d        = w_d_shift[15:0] - g_q;
                    qd_d[cnt_q] = 1'b1;
                end else begin
                    rd_d = w_d_shift[15:0];
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    red_num_d = qn_d;
                    red_den_d = qd_d;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= 16'd0;
            den_q     <= 16'd0;
            g_q       <= 16'd0;
            rn_q      <= 16'd0;
            rd_q      <= 16'd0;
            qn_q      <= 16'd0;
            qd_q      <= 16'd0;
            red_num_q <= 16'd0;
            red_den_q <= 16'd0;
            err_q     <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            den_q     <= den_d;
            g_q       <= g_d;
            rn_q      <= rn_d;
            rd_q      <= rd_d;
            qn_q      <= qn_d;
            qd_q      <= qd_d;
            red_num_q <= red_num_d;
            red_den_q <= red_den_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.gcd_start = (state_q == REQ) && !bus.gcd_done;
    assign bus.gcd_a     = num_q;
    assign bus.gcd_b     = den_q;
    assign bus.red_num   = red_num_q;
    assign bus.red_den   = red_den_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_fraction_reducer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fraction_reducer
// Brief   : Directed self-checking bench with a behavioural GCD core.
// Revision: 1.0
// ============================================================================
module tb_fraction_reducer;
    logic clk;
    logic rst_n;
    logic stray;
    int   n_cmp;
    int   n_fail;

    fraction_reducer_if bus ();

    fraction_reducer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural GCD core: variable latency, done held two cycles.
    logic [1:0]  cm_state;
    logic [15:0] cm_a, cm_b, cm_res;
    logic [3:0]  cm_cnt;

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm_state <= 2'd0;
            cm_a     <= 16'd0;
            cm_b     <= 16'd0;
            cm_res   <= 16'd0;
            cm_cnt   <= 4'd0;
        end else begin
            case (cm_state)
                2'd0: if (bus.gcd_start) begin
                    cm_a     <= bus.gcd_a;
                    cm_b     <= bus.gcd_b;
                    cm_cnt   <= 4'd3 + {2'b00, bus.gcd_a[1:0]};
                    cm_state <= 2'd1;
                end
                2'd1: if (cm_cnt == 4'd0) begin
                    cm_res   <= ref_gcd(cm_a, cm_b);
                    cm_state <= 2'd2;
                end else begin
                    cm_cnt <= cm_cnt - 4'd1;
                end
                2'd2: cm_state <= 2'd3;
                default: cm_state <= 2'd0;
            endcase
        end
    end

    assign bus.gcd_done   = (cm_state == 2'd2) || (cm_state == 2'd3) || stray;
    assign bus.gcd_result = cm_res;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Protocol monitor: single-cycle start, never with done, operands stable.
    logic        prev_start;
    logic        watch;
    logic [15:0] wa, wb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gcd_start) begin
                chk("start_while_done", {31'd0, bus.gcd_done}, 0);
                chk("start_single_cycle", {31'd0, prev_start}, 0);
                watch = 1'b1;
                wa    = bus.gcd_a;
                wb    = bus.gcd_b;
            end else if (watch) begin
                chk("gcd_a_stable", {16'd0, bus.gcd_a}, {16'd0, wa});
                chk("gcd_b_stable", {16'd0, bus.gcd_b}, {16'd0, wb});
                if (bus.gcd_done) watch = 1'b0;
            end
            prev_start = bus.gcd_start;
        end else begin
            watch      = 1'b0;
            prev_start = 1'b0;
        end
    end

    task automatic check_reset();
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_gcd_start", {31'd0, bus.gcd_start}, 0);
        chk("rst_err",       {31'd0, bus.err}, 0);
        chk("rst_gcd_a",     {16'd0, bus.gcd_a}, 0);
        chk("rst_gcd_b",     {16'd0, bus.gcd_b}, 0);
        chk("rst_red_num",   {16'd0, bus.red_num}, 0);
        chk("rst_red_den",   {16'd0, bus.red_den}, 0);
    endtask

    // One fraction end to end; hold = cycles of out_ready low once out_valid rises.
    task automatic do_frac(input logic [15:0] n, input logic [15:0] d,
                           input logic [15:0] en, input logic [15:0] ed,
                           input logic ee, input int hold);
        int k, t_done, t_out, starts;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 1);
        chk("out_valid_idle", {31'd0, bus.out_valid}, 0);
        bus.num       = n;
        bus.den       = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.num      = 16'hDEAD;
        bus.den      = 16'hBEEF;
        k = 1; t_done = -1; t_out = -1; starts = 0;
        while (t_out < 0 && k < 200) begin
            @(negedge clk);
            if (bus.gcd_start) starts++;
            if (bus.gcd_done && starts > 0 && t_done < 0) t_done = k;
            if (bus.out_valid) begin
                t_out = k;
                chk("red_num", {16'd0, bus.red_num}, {16'd0, en});
                chk("red_den", {16'd0, bus.red_den}, {16'd0, ed});
                chk("err",     {31'd0, bus.err}, {31'd0, ee});
                chk("in_ready_busy", {31'd0, bus.in_ready}, 0);
                for (int j = 0; j < hold; j++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("bp_out_valid", {31'd0, bus.out_valid}, 1);
                    chk("bp_red_num", {16'd0, bus.red_num}, {16'd0, en});
                    chk("bp_red_den", {16'd0, bus.red_den}, {16'd0, ed});
                    chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
                end
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            k++;
        end
        chk("out_seen", {31'd0, t_out >= 0}, 1);
        chk("done_seen", {31'd0, t_done >= 0}, 1);
        chk("start_pulses", starts, 1);
        if (t_out >= 0 && t_done >= 0)
            chk("out_latency", t_out - t_done, ee ? 1 : 17);
    endtask

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] en;
        logic [15:0] ed;
        logic        ee;
    } vec_t;

    localparam int NV = 12;

    initial begin
        vec_t vec [NV];
        int   k, t;
        vec[0]  = '{16'd12,    16'd18,    16'd2,     16'd3,     1'b0};
        vec[1]  = '{16'd0,     16'd5,     16'd0,     16'd1,     1'b0};
        vec[2]  = '{16'd7,     16'd0,     16'd1,     16'd0,     1'b0};
        vec[3]  = '{16'd65535, 16'd65535, 16'd1,     16'd1,     1'b0};
        vec[4]  = '{16'd65535, 16'd1,     16'd65535, 16'd1,     1'b0};
        vec[5]  = '{16'd0,     16'd0,     16'd0,     16'd0,     1'b1};
        vec[6]  = '{16'd4,     16'd6,     16'd2,     16'd3,     1'b0};
        vec[7]  = '{16'd6,     16'd4,     16'd3,     16'd2,     1'b0};
        vec[8]  = '{16'd5,     16'd10,    16'd1,     16'd2,     1'b0};
        vec[9]  = '{16'd21,    16'd14,    16'd3,     16'd2,     1'b0};
        vec[10] = '{16'd1000,  16'd250,   16'd4,     16'd1,     1'b0};
        vec[11] = '{16'd65534, 16'd32767, 16'd2,     16'd1,     1'b0};

        n_cmp = 0; n_fail = 0;
        clk = 1'b0; rst_n = 1'b0; stray = 1'b0;
        bus.in_valid = 1'b0; bus.num = 16'd0; bus.den = 16'd0; bus.out_ready = 1'b1;
        #12;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            do_frac(vec[i].n, vec[i].d, vec[i].en, vec[i].ed, vec[i].ee, 0);

        do_frac(16'd40, 16'd100, 16'd2, 16'd5, 1'b0, 5);

        // Done already high on acceptance: the request must wait it out.
        @(negedge clk);
        stray = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                #2 stray = 1'b0;
            end
            do_frac(16'd8, 16'd12, 16'd2, 16'd3, 1'b0, 0);
        join

        // Reset in the middle of the divide phase.
        @(negedge clk);
        bus.num = 16'd100; bus.den = 16'd75; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        k = 1; t = -1;
        while (t < 0 && k < 200) begin
            @(negedge clk);
            if (bus.gcd_done) t = k;
            else k++;
        end
        chk("mid_done_seen", {31'd0, t >= 0}, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("no_stale_out", {31'd0, bus.out_valid}, 0);
        end
        do_frac(16'd9, 16'd27, 16'd1, 16'd3, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual %0d required %0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
